// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file constants and the write-back controller state type.
//   RF_DATA_W   register width
//   RF_ADDR_W   register address width
//   RF_NUM_REGS registers in the file
package rf_pkg;
    localparam int RF_DATA_W   = 16;
    localparam int RF_ADDR_W   = 4;
    localparam int RF_NUM_REGS = 16;
    typedef enum logic {RUN, CLEAR} wb_state_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: write-back requester bus, clear control and register-file write port.
//   master: requesters / software side (drives req_*, clr_start)
//   slave : rf_wb_arbiter (drives req_ready, clr_busy, clr_done, rf_wr_*)
interface rf_wb_arbiter_if
    import rf_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      clr_start;
    logic                      clr_busy;
    logic                      clr_done;
    logic                      rf_wr_en;
    logic [ADDR_W-1:0]         rf_wr_addr;
    logic [DATA_W-1:0]         rf_wr_data;
    modport master (
        output req_valid, req_addr, req_data, clr_start,
        input  req_ready, clr_busy, clr_done, rf_wr_en, rf_wr_addr, rf_wr_data
    );
    modport slave (
        input  req_valid, req_addr, req_data, clr_start,
        output req_ready, clr_busy, clr_done, rf_wr_en, rf_wr_addr, rf_wr_data
    );
endinterface

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority index; search runs upward from here with wrap
//   gnt : one-hot grant, or zero when nothing requests
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    // Walk offsets from farthest to nearest so the nearest request overwrites the rest.
    always_comb begin
        gnt = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) begin
                gnt = '0;
                gnt[(int'(ptr) + k) % N] = 1'b1;
            end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file write port between write-back requesters and runs a zeroing sweep.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requester valid/ready/addr/data, clr_start/busy/done, registered rf_wr_* outputs
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter bit ZERO_R0  = 1'b0
) (
    input logic clk,
    input logic rst,
    rf_wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);
    wb_state_t         state;
    logic [PW-1:0]     rr_ptr, g;
    logic [ADDR_W:0]   clr_cnt;
    logic [NUM_REQ-1:0] gnt;
    logic [ADDR_W-1:0] sel_addr, wr_addr;
    logic [DATA_W-1:0] sel_data, wr_data;
    logic              xfer, wr_en, busy, done;
    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (.req(bus.req_valid), .ptr(rr_ptr), .gnt(gnt));
    // clr_start wins over any request in the same cycle, so the grant is masked by it.
    assign bus.req_ready = (state == RUN && !bus.clr_start && !rst) ? gnt : '0;
    assign xfer = |bus.req_ready;
    always_comb begin
        g = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) g = PW'(i);
    end
    assign sel_addr = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign sel_data = bus.req_data[g*DATA_W +: DATA_W];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            rr_ptr  <= '0;
            clr_cnt <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == CLEAR) begin
                // clr_cnt holds the next address to write; reaching NUM_REGS ends the sweep.
                if (clr_cnt == (ADDR_W+1)'(NUM_REGS)) begin
                    state <= RUN;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    wr_en <= 1'b0;
                end else begin
                    wr_en   <= 1'b1;
                    wr_addr <= clr_cnt[ADDR_W-1:0];
                    clr_cnt <= clr_cnt + 1'b1;
                end
            end else if (bus.clr_start) begin
                state   <= CLEAR;
                busy    <= 1'b1;
                wr_en   <= 1'b1;
                wr_addr <= '0;
                wr_data <= '0;
                clr_cnt <= (ADDR_W+1)'(1);
            end else if (xfer) begin
                wr_en   <= !(ZERO_R0 && sel_addr == '0);
                wr_addr <= sel_addr;
                wr_data <= sel_data;
                rr_ptr  <= (g == PW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
            end else begin
                wr_en <= 1'b0;
            end
        end
    end
    assign bus.rf_wr_en   = wr_en;
    assign bus.rf_wr_addr = wr_addr;
    assign bus.rf_wr_data = wr_data;
    assign bus.clr_busy   = busy;
    assign bus.clr_done   = done;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed and random stimulus on two builds (ZERO_R0=0 and 1) against a behavioural model.
module tb_rf_wb_arbiter;
    import rf_pkg::*;
    localparam int N  = 2;
    localparam int AW = RF_ADDR_W;
    localparam int DW = RF_DATA_W;
    localparam int NR = RF_NUM_REGS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) b0 ();
    rf_wb_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) b1 ();
    rf_wb_arbiter #(.NUM_REQ(N), .ZERO_R0(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    rf_wb_arbiter #(.NUM_REQ(N), .ZERO_R0(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    // stimulus
    logic          v [N];
    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];
    logic          cs;

    // reference model
    int            ptr;
    bit            in_clr;
    int            clr_q[$];
    logic          exp_en0, exp_en1, exp_busy, exp_done;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    int            wait_cnt [N];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ptr = 0;
        in_clr = 0;
        clr_q.delete();
        exp_en0 = 0; exp_en1 = 0; exp_busy = 0; exp_done = 0;
        exp_addr = '0; exp_data = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    endtask

    function automatic int model_gnt();
        if (rst || in_clr || cs) return -1;
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic drive();
        b0.clr_start = cs;
        b1.clr_start = cs;
        for (int i = 0; i < N; i++) begin
            b0.req_valid[i] = v[i];  b1.req_valid[i] = v[i];
            b0.req_addr[i*AW +: AW] = a[i];  b1.req_addr[i*AW +: AW] = a[i];
            b0.req_data[i*DW +: DW] = d[i];  b1.req_data[i*DW +: DW] = d[i];
        end
    endtask

    task automatic step();
        int g;
        logic [N-1:0] er;
        @(negedge clk);
        drive();
        if (rst) model_reset();
        #1;
        g = model_gnt();
        er = (g < 0) ? '0 : N'(1) << g;
        chk("ready0", 32'(b0.req_ready), 32'(er));
        chk("ready1", 32'(b1.req_ready), 32'(er));
        chk("en0", 32'(b0.rf_wr_en), 32'(exp_en0));
        chk("addr0", 32'(b0.rf_wr_addr), 32'(exp_addr));
        chk("data0", 32'(b0.rf_wr_data), 32'(exp_data));
        chk("busy0", 32'(b0.clr_busy), 32'(exp_busy));
        chk("done0", 32'(b0.clr_done), 32'(exp_done));
        chk("en1", 32'(b1.rf_wr_en), 32'(exp_en1));
        chk("busy1", 32'(b1.clr_busy), 32'(exp_busy));
        chk("done1", 32'(b1.clr_done), 32'(exp_done));
        if (exp_en1) begin
            chk("addr1", 32'(b1.rf_wr_addr), 32'(exp_addr));
            chk("data1", 32'(b1.rf_wr_data), 32'(exp_data));
        end
        // a requester that keeps losing in ungated cycles would be starving
        if (!rst && !in_clr && !cs)
            for (int i = 0; i < N; i++)
                if (v[i]) begin
                    if (b0.req_ready[i]) begin
                        chk("starve", 32'(wait_cnt[i] < N), 32'd1);
                        wait_cnt[i] = 0;
                    end else wait_cnt[i]++;
                end
        @(posedge clk);
        if (!rst) begin
            exp_done = 0;
            if (in_clr) begin
                if (clr_q.size() > 0) begin
                    exp_addr = AW'(clr_q.pop_front());
                    exp_data = '0; exp_en0 = 1; exp_en1 = 1;
                end else begin
                    in_clr = 0; exp_busy = 0; exp_done = 1; exp_en0 = 0; exp_en1 = 0;
                end
            end else if (cs) begin
                in_clr = 1; exp_busy = 1; exp_en0 = 1; exp_en1 = 1;
                exp_addr = '0; exp_data = '0;
                for (int r = 1; r < NR; r++) clr_q.push_back(r);
            end else if (g >= 0) begin
                exp_en0 = 1;
                exp_en1 = (a[g] != '0);
                exp_addr = a[g];
                exp_data = d[g];
                ptr = (g + 1) % N;
                v[g] = 0;
            end else begin
                exp_en0 = 0; exp_en1 = 0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin v[i] = 0; a[i] = '0; d[i] = '0; end
        cs = 0;
        rst = 1;
        model_reset();
        repeat (2) step();
        rst = 0;
        repeat (2) step();
        // single request
        v[0] = 1; a[0] = 4'd3; d[0] = 16'hBEEF;
        repeat (2) step();
        // both valid continuously: alternating grants
        for (int c = 0; c < 8; c++) begin
            v[0] = 1; a[0] = 4'd1; d[0] = 16'h1111;
            v[1] = 1; a[1] = 4'd2; d[1] = 16'h2222;
            step();
        end
        v[0] = 0; v[1] = 0;
        step();
        // clear while req0 valid
        v[0] = 1; a[0] = 4'd7; d[0] = 16'h7777;
        cs = 1;
        step();
        cs = 0;
        repeat (NR + 3) step();
        // clr_start during a sweep is ignored
        cs = 1; step();
        cs = 0; repeat (3) step();
        cs = 1; step();
        cs = 0; repeat (NR) step();
        // reset in the middle of a sweep
        cs = 1; step();
        cs = 0; repeat (4) step();
        rst = 1; repeat (2) step();
        rst = 0;
        v[0] = 1; a[0] = 4'd9; d[0] = 16'h0909;
        v[1] = 1; a[1] = 4'd10; d[1] = 16'h0A0A;
        repeat (3) step();
        // address 0 writes (suppressed only in the ZERO_R0 build)
        v[0] = 1; a[0] = 4'd0; d[0] = 16'hAAAA;
        step();
        v[0] = 1; a[0] = 4'd5; d[0] = 16'h5555;
        repeat (2) step();
        // random traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                if (!v[i]) begin
                    v[i] = ($urandom_range(0, 3) != 0);
                    a[i] = AW'($urandom_range(0, 3) == 0 ? 0 : $urandom);
                    d[i] = DW'($urandom);
                end
            cs = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
            cs = 0;
            rst = 0;
        end
        repeat (NR + 2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
